mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch unit, the load/store unit, the
// arbiter and the shared memory port.
//   if_*  : fetch read request (valid/ready/addr) and one-cycle response
//   lsu_* : load/store request (valid/ready/addr/we/wdata/wmask) and response
//   mem_* : shared memory request (valid/ready/addr/we/wdata/wmask) and response
// Modports: slave = the arbiter itself, master = the surrounding environment.
interface mem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            if_req_valid_i;
  logic            if_req_ready_o;
  logic [XLEN-1:0] if_req_addr_i;
  logic            if_rsp_valid_o;
  logic [XLEN-1:0] if_rsp_rdata_o;
  logic            if_rsp_err_o;

  logic            lsu_req_valid_i;
  logic            lsu_req_ready_o;
  logic [XLEN-1:0] lsu_req_addr_i;
  logic            lsu_req_we_i;
  logic [XLEN-1:0] lsu_req_wdata_i;
  logic [3:0]      lsu_req_wmask_i;
  logic            lsu_rsp_valid_o;
  logic [XLEN-1:0] lsu_rsp_rdata_o;
  logic            lsu_rsp_err_o;

  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_req_we_o;
  logic [XLEN-1:0] mem_req_wdata_o;
  logic [3:0]      mem_req_wmask_o;
  logic            mem_rsp_valid_i;
  logic [XLEN-1:0] mem_rsp_rdata_i;
  logic            mem_rsp_err_i;

  modport slave (
    input  if_req_valid_i, if_req_addr_i,
    output if_req_ready_o, if_rsp_valid_o, if_rsp_rdata_o, if_rsp_err_o,
    input  lsu_req_valid_i, lsu_req_addr_i, lsu_req_we_i, lsu_req_wdata_i, lsu_req_wmask_i,
    output lsu_req_ready_o, lsu_rsp_valid_o, lsu_rsp_rdata_o, lsu_rsp_err_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_wmask_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i
  );

  modport master (
    output if_req_valid_i, if_req_addr_i,
    input  if_req_ready_o, if_rsp_valid_o, if_rsp_rdata_o, if_rsp_err_o,
    output lsu_req_valid_i, lsu_req_addr_i, lsu_req_we_i, lsu_req_wdata_i, lsu_req_wmask_i,
    input  lsu_req_ready_o, lsu_rsp_valid_o, lsu_rsp_rdata_o, lsu_rsp_err_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o, mem_req_wmask_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the fetch unit (IF) and the load/store unit (LSU)
// access to a single memory port, one transaction at a time, with a watchdog
// that forces an error response if memory does not answer within TIMEOUT cycles.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_arbiter_if.slave carrying IF, LSU and memory handshakes
module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            owner_q, owner_d;           // 0 = IF, 1 = LSU
  logic            last_grant_q, last_grant_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [3:0]      wmask_q, wmask_d;

  logic            winner;
  logic            win_valid;
  logic            in_idle;
  logic            timeout;
  logic            rsp_from_mem;
  logic            rsp_fire;
  logic            req_out;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  // Both valid: favour whoever did not win last time.
  assign winner    = (bus.if_req_valid_i && bus.lsu_req_valid_i) ? ~last_grant_q
                                                                 : bus.lsu_req_valid_i;
  assign win_valid = bus.if_req_valid_i || bus.lsu_req_valid_i;
  // Gated by reset so the readies are low while reset is held.
  assign in_idle   = (state_q == StIdle) && reset;

  // cnt_q counts completed busy cycles; this is the TIMEOUT-th busy cycle.
  assign timeout      = (state_q != StIdle) && (cnt_q == CntLast);
  assign rsp_from_mem = (state_q == StWait) && bus.mem_rsp_valid_i;
  assign rsp_fire     = rsp_from_mem || timeout;
  // A request timing out in REQ is withdrawn in that same cycle.
  assign req_out      = (state_q == StReq) && !timeout;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    wmask_d      = wmask_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d      = StReq;
          owner_d      = winner;
          last_grant_d = winner;
          cnt_d        = '0;
          if (winner) begin
            addr_d  = bus.lsu_req_addr_i;
            we_d    = bus.lsu_req_we_i;
            wdata_d = bus.lsu_req_wdata_i;
            wmask_d = bus.lsu_req_wmask_i;
          end else begin
            addr_d  = bus.if_req_addr_i;
            we_d    = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout) begin
          state_d = StIdle;
        end else if (bus.mem_req_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (rsp_fire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      wmask_q      <= wmask_d;
    end
  end

  // A memory response beats a simultaneous timeout; a timeout alone is err=1, rdata=0.
  assign rsp_rdata = rsp_from_mem ? bus.mem_rsp_rdata_i : '0;
  assign rsp_err   = rsp_from_mem ? bus.mem_rsp_err_i : timeout;

  always_comb begin
    bus.if_req_ready_o  = in_idle && bus.if_req_valid_i && !winner;
    bus.lsu_req_ready_o = in_idle && bus.lsu_req_valid_i && winner;

    bus.mem_req_valid_o = req_out;
    bus.mem_req_addr_o  = req_out ? addr_q : '0;
    bus.mem_req_we_o    = req_out && we_q;
    bus.mem_req_wdata_o = req_out ? wdata_q : '0;
    bus.mem_req_wmask_o = req_out ? wmask_q : '0;

    bus.if_rsp_valid_o  = rsp_fire && !owner_q;
    bus.if_rsp_rdata_o  = owner_q ? '0 : rsp_rdata;
    bus.if_rsp_err_o    = !owner_q && rsp_err;
    bus.lsu_rsp_valid_o = rsp_fire && owner_q;
    bus.lsu_rsp_rdata_o = owner_q ? rsp_rdata : '0;
    bus.lsu_rsp_err_o   = owner_q && rsp_err;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] Key  = 32'h0000_0113;  // memory model: rdata = addr ^ Key

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.XLEN(XLEN)) bus ();
  mem_arbiter_if #(.XLEN(XLEN)) bus_to ();

  mem_arbiter #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(4)) dut_to (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_to)
  );

  typedef struct packed {
    logic        port;  // 0 = IF, 1 = LSU
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int   checks   = 0;
  int   failures = 0;
  int   pushed   = 0;
  int   rsp_seen = 0;
  rsp_t exp_q[$];
  rsp_t mon_exp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ Key;
  endfunction

  function automatic void expect_rsp(input logic port, input logic [31:0] a);
    rsp_t r;
    r.port  = port;
    r.rdata = mem_data(a);
    r.err   = a[31];
    exp_q.push_back(r);
    pushed++;
  endfunction

  // Memory model for the main DUT: ready after ready_delay stalled cycles,
  // response rsp_delay cycles after the request is taken.
  int          ready_delay = 0;
  int          rsp_delay   = 0;
  int          hold_cnt    = 0;
  int          wait_cnt    = 0;
  bit          pending     = 1'b0;
  logic [31:0] pend_addr   = '0;

  always @(negedge clk) begin
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_rdata_i = '0;
    bus.mem_rsp_err_i   = 1'b0;
    if (!reset) begin
      pending  = 1'b0;
      hold_cnt = 0;
      wait_cnt = 0;
    end else if (pending) begin
      if (wait_cnt >= rsp_delay) begin
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_rdata_i = mem_data(pend_addr);
        bus.mem_rsp_err_i   = pend_addr[31];
        pending  = 1'b0;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else if (bus.mem_req_valid_o) begin
      if (hold_cnt < ready_delay) begin
        hold_cnt++;
      end else begin
        bus.mem_req_ready_i = 1'b1;
        pending   = 1'b1;
        pend_addr = bus.mem_req_addr_o;
        hold_cnt  = 0;
      end
    end
  end

  // Response monitor for the main DUT.
  always @(negedge clk) begin
    #2;
    if (bus.if_rsp_valid_o || bus.lsu_rsp_valid_o) begin
      rsp_seen++;
      check_eq("rsp_onehot", 64'(bus.if_rsp_valid_o && bus.lsu_rsp_valid_o), 64'(0));
      check_eq("rsp_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check_eq("rsp_port", 64'(bus.lsu_rsp_valid_o), 64'(mon_exp.port));
        check_eq("rsp_rdata", 64'(bus.lsu_rsp_valid_o ? bus.lsu_rsp_rdata_o : bus.if_rsp_rdata_o),
                 64'(mon_exp.rdata));
        check_eq("rsp_err", 64'(bus.lsu_rsp_valid_o ? bus.lsu_rsp_err_o : bus.if_rsp_err_o),
                 64'(mon_exp.err));
      end
    end
    if (!bus.if_rsp_valid_o) begin
      check_eq("if_rsp_quiet", 64'({bus.if_rsp_rdata_o, bus.if_rsp_err_o}), 64'(0));
    end
    if (!bus.lsu_rsp_valid_o) begin
      check_eq("lsu_rsp_quiet", 64'({bus.lsu_rsp_rdata_o, bus.lsu_rsp_err_o}), 64'(0));
    end
  end

  task automatic if_req(input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = a;
    while (1) begin
      #1;
      if (bus.if_req_ready_o) break;
      n++;
      if (n > 200) begin
        check_eq("if_accept", 64'(bus.if_req_ready_o), 64'(1));
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.if_req_valid_i = 1'b0;
  endtask

  task automatic lsu_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] wm);
    int n = 0;
    @(negedge clk);
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_req_addr_i  = a;
    bus.lsu_req_we_i    = we;
    bus.lsu_req_wdata_i = wd;
    bus.lsu_req_wmask_i = wm;
    while (1) begin
      #1;
      if (bus.lsu_req_ready_o) break;
      n++;
      if (n > 200) begin
        check_eq("lsu_accept", 64'(bus.lsu_req_ready_o), 64'(1));
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.lsu_req_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    bus.if_req_valid_i     = 1'b0;
    bus.if_req_addr_i      = '0;
    bus.lsu_req_valid_i    = 1'b0;
    bus.lsu_req_addr_i     = '0;
    bus.lsu_req_we_i       = 1'b0;
    bus.lsu_req_wdata_i    = '0;
    bus.lsu_req_wmask_i    = '0;
    bus_to.if_req_valid_i  = 1'b0;
    bus_to.if_req_addr_i   = '0;
    bus_to.lsu_req_valid_i = 1'b0;
    bus_to.lsu_req_addr_i  = '0;
    bus_to.lsu_req_we_i    = 1'b0;
    bus_to.lsu_req_wdata_i = '0;
    bus_to.lsu_req_wmask_i = '0;
    bus_to.mem_req_ready_i = 1'b0;
    bus_to.mem_rsp_valid_i = 1'b0;
    bus_to.mem_rsp_rdata_i = '0;
    bus_to.mem_rsp_err_i   = 1'b0;

    // Reset state: outputs low even with requests pending.
    repeat (2) @(negedge clk);
    bus.if_req_valid_i  = 1'b1;
    bus.lsu_req_valid_i = 1'b1;
    #1;
    check_eq("rst_if_ready", 64'(bus.if_req_ready_o), 64'(0));
    check_eq("rst_lsu_ready", 64'(bus.lsu_req_ready_o), 64'(0));
    check_eq("rst_mem_valid", 64'(bus.mem_req_valid_o), 64'(0));
    check_eq("rst_rsp", 64'({bus.if_rsp_valid_o, bus.lsu_rsp_valid_o}), 64'(0));
    @(negedge clk);
    bus.if_req_valid_i  = 1'b0;
    bus.lsu_req_valid_i = 1'b0;
    reset = 1'b1;

    // Single IF read, minimum latency.
    expect_rsp(1'b0, 32'h100);
    @(negedge clk);
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 32'h100;
    #1;
    check_eq("a_if_ready", 64'(bus.if_req_ready_o), 64'(1));
    check_eq("a_lsu_ready", 64'(bus.lsu_req_ready_o), 64'(0));
    @(negedge clk);
    bus.if_req_valid_i = 1'b0;
    #1;
    check_eq("a_mem_valid", 64'(bus.mem_req_valid_o), 64'(1));
    check_eq("a_mem_addr", 64'(bus.mem_req_addr_o), 64'(32'h100));
    check_eq("a_mem_fields", 64'({bus.mem_req_we_o, bus.mem_req_wdata_o, bus.mem_req_wmask_o}),
             64'(0));
    @(negedge clk);
    #1;
    check_eq("a_if_rsp", 64'(bus.if_rsp_valid_o), 64'(1));
    check_eq("a_if_rdata", 64'(bus.if_rsp_rdata_o), 64'(32'h13));
    check_eq("a_lsu_rsp", 64'(bus.lsu_rsp_valid_o), 64'(0));
    @(negedge clk);
    #1;
    check_eq("a_rsp_pulse", 64'(bus.if_rsp_valid_o), 64'(0));
    check_eq("a_mem_idle", 64'(bus.mem_req_valid_o), 64'(0));

    // Round robin: LSU first, then strict alternation while both stay busy.
    expect_rsp(1'b1, 32'h10);
    expect_rsp(1'b0, 32'h20);
    expect_rsp(1'b1, 32'h14);
    expect_rsp(1'b0, 32'h24);
    expect_rsp(1'b1, 32'h8000_0018);
    expect_rsp(1'b0, 32'h28);
    fork
      begin
        if_req(32'h20);
        if_req(32'h24);
        if_req(32'h28);
      end
      begin
        lsu_req(32'h10, 1'b0, '0, '0);
        lsu_req(32'h14, 1'b0, '0, '0);
        lsu_req(32'h8000_0018, 1'b0, '0, '0);
      end
    join
    repeat (4) @(negedge clk);

    // Store held while memory stalls; nobody else is granted meanwhile.
    ready_delay = 3;
    expect_rsp(1'b1, 32'h200);
    expect_rsp(1'b0, 32'h300);
    @(negedge clk);
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_req_addr_i  = 32'h200;
    bus.lsu_req_we_i    = 1'b1;
    bus.lsu_req_wdata_i = 32'hDEAD_BEEF;
    bus.lsu_req_wmask_i = 4'hF;
    #1;
    check_eq("c_lsu_ready", 64'(bus.lsu_req_ready_o), 64'(1));
    @(negedge clk);
    bus.lsu_req_valid_i = 1'b0;
    bus.lsu_req_we_i    = 1'b0;
    bus.if_req_valid_i  = 1'b1;
    bus.if_req_addr_i   = 32'h300;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("c_mem_valid", 64'(bus.mem_req_valid_o), 64'(1));
      check_eq("c_mem_addr", 64'(bus.mem_req_addr_o), 64'(32'h200));
      check_eq("c_mem_we", 64'(bus.mem_req_we_o), 64'(1));
      check_eq("c_mem_wdata", 64'(bus.mem_req_wdata_o), 64'(32'hDEAD_BEEF));
      check_eq("c_mem_wmask", 64'(bus.mem_req_wmask_o), 64'(4'hF));
      check_eq("c_readies", 64'({bus.if_req_ready_o, bus.lsu_req_ready_o}), 64'(0));
      @(negedge clk);
    end
    n = 0;
    while (n < 50) begin
      #1;
      if (bus.if_req_ready_o) break;
      @(negedge clk);
      n++;
    end
    check_eq("c_if_accept", 64'(bus.if_req_ready_o), 64'(1));
    @(negedge clk);
    bus.if_req_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    ready_delay = 0;

    // Reset while waiting for memory: transaction dropped, then normal service.
    rsp_delay = 5;
    @(negedge clk);
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 32'h500;
    @(negedge clk);
    bus.if_req_valid_i = 1'b0;
    @(negedge clk);
    bus.if_req_valid_i  = 1'b1;
    bus.lsu_req_valid_i = 1'b1;
    reset = 1'b0;
    #1;
    check_eq("d_readies", 64'({bus.if_req_ready_o, bus.lsu_req_ready_o}), 64'(0));
    check_eq("d_mem_valid", 64'(bus.mem_req_valid_o), 64'(0));
    check_eq("d_mem_addr", 64'(bus.mem_req_addr_o), 64'(0));
    check_eq("d_rsp", 64'({bus.if_rsp_valid_o, bus.lsu_rsp_valid_o}), 64'(0));
    @(negedge clk);
    bus.if_req_valid_i  = 1'b0;
    bus.lsu_req_valid_i = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    rsp_delay = 0;
    repeat (8) @(negedge clk);
    expect_rsp(1'b0, 32'h100);
    if_req(32'h100);
    repeat (4) @(negedge clk);

    // Timeout (TIMEOUT=4) while in WAIT; a late response is ignored.
    bus_to.mem_req_ready_i = 1'b1;
    @(negedge clk);
    bus_to.lsu_req_valid_i = 1'b1;
    bus_to.lsu_req_addr_i  = 32'h400;
    #1;
    check_eq("e_lsu_ready", 64'(bus_to.lsu_req_ready_o), 64'(1));
    @(negedge clk);
    bus_to.lsu_req_valid_i = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check_eq("e_no_early_rsp", 64'(bus_to.lsu_rsp_valid_o), 64'(0));
      @(negedge clk);
    end
    #1;
    check_eq("e_to_valid", 64'(bus_to.lsu_rsp_valid_o), 64'(1));
    check_eq("e_to_err", 64'(bus_to.lsu_rsp_err_o), 64'(1));
    check_eq("e_to_rdata", 64'(bus_to.lsu_rsp_rdata_o), 64'(0));
    check_eq("e_to_if_quiet", 64'(bus_to.if_rsp_valid_o), 64'(0));
    @(negedge clk);
    bus_to.mem_rsp_valid_i = 1'b1;
    bus_to.mem_rsp_rdata_i = 32'hFFFF_0000;
    #1;
    check_eq("e_late_ignored", 64'({bus_to.if_rsp_valid_o, bus_to.lsu_rsp_valid_o}), 64'(0));
    @(negedge clk);
    bus_to.mem_rsp_valid_i = 1'b0;
    bus_to.mem_rsp_rdata_i = '0;

    // Timeout while still in REQ: the request is withdrawn.
    bus_to.mem_req_ready_i = 1'b0;
    @(negedge clk);
    bus_to.if_req_valid_i = 1'b1;
    bus_to.if_req_addr_i  = 32'h440;
    #1;
    check_eq("f_if_ready", 64'(bus_to.if_req_ready_o), 64'(1));
    @(negedge clk);
    bus_to.if_req_valid_i = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check_eq("f_mem_valid", 64'(bus_to.mem_req_valid_o), 64'(1));
      @(negedge clk);
    end
    #1;
    check_eq("f_to_valid", 64'(bus_to.if_rsp_valid_o), 64'(1));
    check_eq("f_to_err", 64'(bus_to.if_rsp_err_o), 64'(1));
    check_eq("f_mem_dropped", 64'(bus_to.mem_req_valid_o), 64'(0));
    @(negedge clk);
    bus_to.mem_req_ready_i = 1'b1;
    #1;
    check_eq("f_abandoned", 64'(bus_to.mem_req_valid_o), 64'(0));

    // Response in the very cycle the counter expires wins over the timeout.
    @(negedge clk);
    bus_to.lsu_req_valid_i = 1'b1;
    bus_to.lsu_req_addr_i  = 32'h480;
    @(negedge clk);
    bus_to.lsu_req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    bus_to.mem_rsp_valid_i = 1'b1;
    bus_to.mem_rsp_rdata_i = 32'h1234_5678;
    bus_to.mem_rsp_err_i   = 1'b0;
    #1;
    check_eq("g_rsp_valid", 64'(bus_to.lsu_rsp_valid_o), 64'(1));
    check_eq("g_rsp_rdata", 64'(bus_to.lsu_rsp_rdata_o), 64'(32'h1234_5678));
    check_eq("g_rsp_err", 64'(bus_to.lsu_rsp_err_o), 64'(0));
    @(negedge clk);
    bus_to.mem_rsp_valid_i = 1'b0;
    bus_to.mem_rsp_rdata_i = '0;
    repeat (2) @(negedge clk);

    check_eq("sb_drained", 64'(exp_q.size()), 64'(0));
    check_eq("rsp_count", 64'(rsp_seen), 64'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
